// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and state encoding for the pipeline sequencer.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  localparam logic [5:0]  STALL_NONE = 6'b000000;
  localparam logic [5:0]  STALL_ID   = 6'b000111;
  localparam logic [5:0]  STALL_EX   = 6'b001111;

  localparam logic [31:0] EXCP_VECTOR_DEF = 32'h0000_0020;
  localparam int          MC_LEN_W_DEF    = 6;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Pipeline-to-sequencer bus: hazard/multi-cycle/exception requests in, stall/flush/redirect out.
interface pipe_ctrl_if #(
  parameter int MC_LEN_W = 6
);
  logic                stallreq_id;
  logic                stallreq_ex;
  logic                mc_start;
  logic [MC_LEN_W-1:0] mc_len;
  logic                mc_abort;
  logic                excp_valid;
  logic                eret;
  logic [31:0]         cp0_epc;
  logic [5:0]          stall;
  logic                flush;
  logic [31:0]         new_pc;
  logic                mc_busy;
  logic                mc_done;

  modport master (
    output stallreq_id, stallreq_ex, mc_start, mc_len, mc_abort,
           excp_valid, eret, cp0_epc,
    input  stall, flush, new_pc, mc_busy, mc_done
  );

  modport slave (
    input  stallreq_id, stallreq_ex, mc_start, mc_len, mc_abort,
           excp_valid, eret, cp0_epc,
    output stall, flush, new_pc, mc_busy, mc_done
  );
endinterface

// File: rtl/pipe_ctrl_mc_timer.sv
// Loadable down-counter timing the remaining cycles of a multi-cycle EX operation.
module mc_timer #(
  parameter int MC_LEN_W = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [MC_LEN_W-1:0] load_val,
  input  logic                dec,
  input  logic                abort,
  input  logic                clear,
  output logic                last
);

  logic [MC_LEN_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear || abort) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - MC_LEN_W'(1);
    end
  end

  assign last = (cnt == MC_LEN_W'(1));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges stall requests, times mult/div, turns exceptions/ERET into flush+redirect.
// Optional PIPE_CTRL_PERF_EN adds stall_cycles/flush_count performance counters.
//
// state    | meaning
// ST_IDLE  | no multi-cycle op; hazard stalls, mc_start and exceptions accepted
// ST_RUN   | multi-cycle op running, front end held
// ST_FLUSH | one dead cycle after a flush, all requests ignored
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXCP_VECTOR = EXCP_VECTOR_DEF,
  parameter int          MC_LEN_W    = MC_LEN_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  bus
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
`endif
);

  state_e              state, state_n;
  logic [MC_LEN_W-1:0] mc_n;
  logic                t_load, t_dec, t_abort, t_clear, t_last;
  logic [5:0]          stall;
  logic                flush, mc_busy, mc_done;
  logic [31:0]         new_pc;

  mc_timer #(.MC_LEN_W(MC_LEN_W)) u_mc_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (t_load),
    .load_val (mc_n - MC_LEN_W'(1)),
    .dec      (t_dec),
    .abort    (t_abort),
    .clear    (t_clear),
    .last     (t_last)
  );

  assign mc_n = (bus.mc_len == '0) ? MC_LEN_W'(1) : bus.mc_len;

  // Outputs are held quiet while reset is asserted even if requests are already active.
  always_comb begin
    stall   = STALL_NONE;
    flush   = 1'b0;
    new_pc  = '0;
    mc_busy = 1'b0;
    mc_done = 1'b0;
    state_n = state;
    t_load  = 1'b0;
    t_dec   = 1'b0;
    t_abort = 1'b0;
    t_clear = 1'b0;
    if (rst) begin
      unique case (state)
        ST_IDLE: begin
          if (bus.excp_valid) begin
            flush   = 1'b1;
            new_pc  = bus.eret ? bus.cp0_epc : EXCP_VECTOR;
            t_clear = 1'b1;
            state_n = ST_FLUSH;
          end else if (bus.mc_start) begin
            stall = STALL_EX;
            if (mc_n == MC_LEN_W'(1)) begin
              mc_done = 1'b1;
            end else begin
              t_load  = 1'b1;
              state_n = ST_RUN;
            end
          end else if (bus.stallreq_ex) begin
            stall = STALL_EX;
          end else if (bus.stallreq_id) begin
            stall = STALL_ID;
          end
        end
        ST_RUN: begin
          mc_busy = 1'b1;
          if (bus.excp_valid) begin
            flush   = 1'b1;
            new_pc  = bus.eret ? bus.cp0_epc : EXCP_VECTOR;
            t_clear = 1'b1;
            state_n = ST_FLUSH;
          end else if (bus.mc_abort) begin
            stall   = STALL_EX;
            t_abort = 1'b1;
            state_n = ST_IDLE;
          end else begin
            stall = STALL_EX;
            if (t_last) begin
              mc_done = 1'b1;
              state_n = ST_IDLE;
            end else begin
              t_dec = 1'b1;
            end
          end
        end
        ST_FLUSH: state_n = ST_IDLE;
        default:  state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_n;
  end

  assign bus.stall   = stall;
  assign bus.flush   = flush;
  assign bus.new_pc  = new_pc;
  assign bus.mc_busy = mc_busy;
  assign bus.mc_done = mc_done;

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall[0]) stall_cycles <= stall_cycles + 32'd1;
      if (flush)    flush_count  <= flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed vector bench for pipe_ctrl: per-cycle table plus hand sequences for abort and long ops.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipe_ctrl_if #(.MC_LEN_W(6)) bus ();

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles, flush_count;
`endif

  pipe_ctrl #(.EXCP_VECTOR(32'h0000_0020), .MC_LEN_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
`endif
  );

  typedef struct {
    logic        rst;
    logic        id;
    logic        ex;
    logic        st;
    logic [5:0]  len;
    logic        ab;
    logic        xv;
    logic        er;
    logic [31:0] epc;
    logic [5:0]  e_stall;
    logic        e_flush;
    logic [31:0] e_pc;
    logic        e_busy;
    logic        e_done;
  } vec_t;

  vec_t vecs[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic id, input logic ex, input logic st,
                     input logic [5:0] len, input logic ab, input logic xv, input logic er,
                     input logic [31:0] epc, input logic [5:0] es, input logic ef,
                     input logic [31:0] ep, input logic eb, input logic ed);
    vec_t v;
    v = '{r, id, ex, st, len, ab, xv, er, epc, es, ef, ep, eb, ed};
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    rst             = v.rst;
    bus.stallreq_id = v.id;
    bus.stallreq_ex = v.ex;
    bus.mc_start    = v.st;
    bus.mc_len      = v.len;
    bus.mc_abort    = v.ab;
    bus.excp_valid  = v.xv;
    bus.eret        = v.er;
    bus.cp0_epc     = v.epc;
  endtask

  task automatic idle_inputs();
    vec_t v;
    v = '{1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 32'h0, 6'd0, 1'b0, 32'h0, 1'b0, 1'b0};
    drive(v);
  endtask

  task automatic check_outputs(input vec_t v, input int idx);
    chk($sformatf("v%0d stall", idx), {26'd0, bus.stall}, {26'd0, v.e_stall});
    chk($sformatf("v%0d flush", idx), {31'd0, bus.flush}, {31'd0, v.e_flush});
    chk($sformatf("v%0d new_pc", idx), bus.new_pc, v.e_pc);
    chk($sformatf("v%0d mc_busy", idx), {31'd0, bus.mc_busy}, {31'd0, v.e_busy});
    chk($sformatf("v%0d mc_done", idx), {31'd0, bus.mc_done}, {31'd0, v.e_done});
    chk($sformatf("v%0d exclusive", idx), {31'd0, (bus.flush && bus.stall != 6'd0)}, 32'd0);
  endtask

  initial begin
    int   cyc;
    int   ndone;
    logic seen_zero;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] sc0, fc0;
`endif
    // rst id ex st len ab xv er epc | stall flush pc busy done
    add(0,0,1,0,0,0,0,0,0,          6'b000000,0,32'h0,0,0);
    add(0,0,1,0,0,0,0,0,0,          6'b000000,0,32'h0,0,0);
    add(1,0,1,0,0,0,0,0,0,          6'b001111,0,32'h0,0,0);
    add(1,1,0,0,0,0,0,0,0,          6'b000111,0,32'h0,0,0);
    add(1,1,0,0,0,0,0,0,0,          6'b000111,0,32'h0,0,0);
    add(1,1,0,0,0,0,0,0,0,          6'b000111,0,32'h0,0,0);
    add(1,0,0,0,0,0,0,0,0,          6'b000000,0,32'h0,0,0);
    add(1,1,0,0,0,1,0,0,0,          6'b000111,0,32'h0,0,0);
    // mc_len=5: five stalled cycles, mc_start re-asserted in RUN is ignored
    add(1,0,0,1,5,0,0,0,0,          6'b001111,0,32'h0,0,0);
    add(1,0,0,1,5,0,0,0,0,          6'b001111,0,32'h0,1,0);
    add(1,0,0,0,0,0,0,0,0,          6'b001111,0,32'h0,1,0);
    add(1,0,0,0,0,0,0,0,0,          6'b001111,0,32'h0,1,0);
    add(1,0,0,0,0,0,0,0,0,          6'b001111,0,32'h0,1,1);
    add(1,0,0,0,0,0,0,0,0,          6'b000000,0,32'h0,0,0);
    add(1,0,0,1,0,0,0,0,0,          6'b001111,0,32'h0,0,1);
    add(1,0,0,0,0,0,0,0,0,          6'b000000,0,32'h0,0,0);
    add(1,0,0,1,1,0,0,0,0,          6'b001111,0,32'h0,0,1);
    add(1,0,0,0,0,0,0,0,0,          6'b000000,0,32'h0,0,0);
    // mc_len=8 killed by exception on the third stall cycle
    add(1,0,0,1,8,0,0,0,0,          6'b001111,0,32'h0,0,0);
    add(1,0,0,0,0,0,0,0,0,          6'b001111,0,32'h0,1,0);
    add(1,0,0,0,0,0,1,0,32'h5555,   6'b000000,1,32'h20,1,0);
    add(1,0,0,0,0,0,0,0,0,          6'b000000,0,32'h0,0,0);
    add(1,0,0,0,0,0,0,0,0,          6'b000000,0,32'h0,0,0);
    add(1,0,0,0,0,0,0,0,0,          6'b000000,0,32'h0,0,0);
    // ERET, excp_valid held into the FLUSH cycle
    add(1,0,0,0,0,0,1,1,32'h1234,   6'b000000,1,32'h1234,0,0);
    add(1,1,1,1,3,0,1,1,32'h1234,   6'b000000,0,32'h0,0,0);
    add(1,0,0,0,0,0,0,0,0,          6'b000000,0,32'h0,0,0);
    // all requests at once in IDLE, mc_len=2
    add(1,1,1,1,2,0,0,0,0,          6'b001111,0,32'h0,0,0);
    add(1,1,1,0,0,0,0,0,0,          6'b001111,0,32'h0,1,1);
    add(1,0,0,0,0,0,0,0,0,          6'b000000,0,32'h0,0,0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      check_outputs(vecs[i], i);
    end

    // abort mid-op: stall held that cycle, no mc_done, back to idle
    @(negedge clk); idle_inputs(); bus.mc_start = 1'b1; bus.mc_len = 6'd10;
    @(negedge clk); idle_inputs();
    #1 chk("abort pre busy", {31'd0, bus.mc_busy}, 32'd1);
    @(negedge clk); bus.mc_abort = 1'b1;
    #1 chk("abort stall", {26'd0, bus.stall}, {26'd0, STALL_EX});
    chk("abort done", {31'd0, bus.mc_done}, 32'd0);
    @(negedge clk); idle_inputs();
    #1 chk("post abort stall", {26'd0, bus.stall}, 32'd0);
    chk("post abort busy", {31'd0, bus.mc_busy}, 32'd0);

    // longest op: count stall cycles until release, bounded
    @(negedge clk); idle_inputs(); bus.mc_start = 1'b1; bus.mc_len = 6'd63;
`ifdef PIPE_CTRL_PERF_EN
    sc0 = stall_cycles;
    fc0 = flush_count;
`endif
    cyc = 0; ndone = 0; seen_zero = 1'b0;
    #1;
    while (!seen_zero && cyc < 100) begin
      if (bus.stall == STALL_EX) begin
        cyc++;
        if (bus.mc_done) ndone++;
        @(negedge clk); idle_inputs(); #1;
      end else begin
        seen_zero = 1'b1;
      end
    end
    chk("len63 released", {31'd0, seen_zero}, 32'd1);
    chk("len63 cycles", cyc, 32'd63);
    chk("len63 done count", ndone, 32'd1);
`ifdef PIPE_CTRL_PERF_EN
    chk("perf stall_cycles", stall_cycles - sc0, 32'd63);
    @(negedge clk); bus.excp_valid = 1'b1;
    @(negedge clk); idle_inputs();
    @(negedge clk);
    #1 chk("perf flush_count", flush_count - fc0, 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
